// File: rtl/ram_be.sv
// Single-port word memory with byte-enable writes, registered read-first output,
// address range checking and an optional zero-fill sequence after reset.
module ram_be #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 16,
    parameter int ADDR_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r_en,
    input  logic                  w_en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     Dato,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     resRAM,
    output logic                  r_valid,
    output logic                  busy,
    output logic                  addr_err
);

    localparam int   IDX_W  = $clog2(DEPTH);
    localparam int   BE_W   = DATA_W / 8;
    localparam logic CLR_EN = (CLEAR_ON_RESET != 0);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              accept;

    // Any set bit above the index field makes the address out of range.
    assign in_range = (addr >> IDX_W) == '0;
    assign idx      = addr[IDX_W-1:0];
    assign accept   = (state == IDLE) && !rst;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   en
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (en[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    // Storage: clear writes take priority; no reset on the array itself.
    always_ff @(posedge clk) begin
        if (!rst && state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (accept && w_en && in_range) begin
            mem[idx] <= merge_bytes(mem[idx], Dato, be);
        end
    end

    // Control FSM and registered read port; the read sees pre-write contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLR_EN ? CLEAR : IDLE;
            busy     <= CLR_EN;
            clr_cnt  <= '0;
            resRAM   <= '0;
            r_valid  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (r_en) begin
                        r_valid <= 1'b1;
                        resRAM  <= in_range ? mem[idx] : '0;
                    end
                    addr_err <= (r_en || w_en) && !in_range;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_be.sv
// Bench for ram_be: a word/byte-level memory model checked every cycle, plus
// directed vectors with literal expectations, on a clearing and a non-clearing instance.
module tb_ram_be;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst, r_en, w_en;
    logic [31:0] addr, dato;
    logic [3:0]  be;
    logic [31:0] res;
    logic        r_valid, busy, addr_err;

    logic        rst0, r_en0, w_en0;
    logic [31:0] addr0, dato0;
    logic [3:0]  be0;
    logic [31:0] res0;
    logic        r_valid0, busy0, addr_err0;

    int errors = 0;
    int checks = 0;

    ram_be #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst(rst), .r_en(r_en), .w_en(w_en), .addr(addr), .Dato(dato),
        .be(be), .resRAM(res), .r_valid(r_valid), .busy(busy), .addr_err(addr_err)
    );

    ram_be #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(0)) dut0 (
        .clk(clk), .rst(rst0), .r_en(r_en0), .w_en(w_en0), .addr(addr0), .Dato(dato0),
        .be(be0), .resRAM(res0), .r_valid(r_valid0), .busy(busy0), .addr_err(addr_err0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model of the clearing instance.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_res;
    logic        m_valid, m_err, m_busy;
    int          clr_left = 0;
    bit          armed = 0;
    bit          armed0 = 0;

    always @(posedge clk) begin
        if (rst) begin
            armed    = 1;
            m_res    = 0;
            m_valid  = 0;
            m_err    = 0;
            clr_left = DEPTH;
        end else if (armed) begin
            m_valid = 0;
            m_err   = 0;
            if (clr_left > 0) begin
                m_mem[DEPTH - clr_left] = 32'h0;
                clr_left--;
            end else begin
                if (r_en) begin
                    m_valid = 1;
                    m_res   = (addr < DEPTH) ? m_mem[addr[3:0]] : 32'h0;
                end
                if ((r_en || w_en) && addr >= DEPTH) m_err = 1;
                if (w_en && addr < DEPTH) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) m_mem[addr[3:0]][8*b +: 8] = dato[8*b +: 8];
                    end
                end
            end
        end
        m_busy = (clr_left > 0);
        if (rst0) armed0 = 1;
    end

    always @(posedge clk) begin
        #1;
        if (armed) begin
            chk("model_resRAM", res, m_res);
            chk("model_r_valid", {31'b0, r_valid}, {31'b0, m_valid});
            chk("model_addr_err", {31'b0, addr_err}, {31'b0, m_err});
            chk("model_busy", {31'b0, busy}, {31'b0, m_busy});
        end
        if (armed0) chk("noclear_busy", {31'b0, busy0}, 32'h0);
    end

    task automatic cyc(input logic rs, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        rst = rs; r_en = r; w_en = w; addr = a; dato = d; be = b;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc0(input logic rs, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        rst0 = rs; r_en0 = r; w_en0 = w; addr0 = a; dato0 = d; be0 = b;
        @(posedge clk);
        #1;
    endtask

    int n;

    initial begin
        rst = 0; r_en = 0; w_en = 0; addr = 0; dato = 0; be = 0;
        rst0 = 0; r_en0 = 0; w_en0 = 0; addr0 = 0; dato0 = 0; be0 = 0;

        // Non-clearing instance: no busy, contents survive reset.
        cyc0(1, 0, 0, 0, 0, 0);
        chk("nc_rst_busy", {31'b0, busy0}, 32'h0);
        chk("nc_rst_res", res0, 32'h0);
        chk("nc_rst_valid", {31'b0, r_valid0}, 32'h0);
        cyc0(0, 0, 1, 2, 32'h0BADF00D, 4'hF);
        chk("nc_first_write_busy", {31'b0, busy0}, 32'h0);
        cyc0(1, 0, 1, 2, 32'h12121212, 4'hF);
        chk("nc_rst_valid2", {31'b0, r_valid0}, 32'h0);
        cyc0(0, 1, 0, 2, 0, 0);
        chk("nc_read_data", res0, 32'h0BADF00D);
        chk("nc_read_valid", {31'b0, r_valid0}, 32'h1);
        cyc0(0, 0, 0, 0, 0, 0);

        // Clearing instance: reset and clear length.
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_busy", {31'b0, busy}, 32'h1);
        chk("rst_res", res, 32'h0);
        chk("rst_valid", {31'b0, r_valid}, 32'h0);
        chk("rst_err", {31'b0, addr_err}, 32'h0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            cyc(0, 0, 0, 0, 0, 0);
        end
        chk("clear_len", n, 16);

        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 1, 0, i, 0, 0);
            chk("clear_read", res, 32'h0);
            chk("clear_read_valid", {31'b0, r_valid}, 32'h1);
        end

        // Byte enables.
        cyc(0, 0, 1, 3, 32'hAABBCCDD, 4'b1111);
        cyc(0, 0, 1, 3, 32'h11223344, 4'b0101);
        cyc(0, 1, 0, 3, 0, 0);
        chk("be_merge", res, 32'hAA22CC44);
        chk("be_merge_valid", {31'b0, r_valid}, 32'h1);
        cyc(0, 0, 1, 3, 32'hFFFFFFFF, 4'b0000);
        cyc(0, 1, 0, 3, 0, 0);
        chk("be_zero", res, 32'hAA22CC44);

        // Read-first collision.
        cyc(0, 0, 1, 5, 32'h12345678, 4'hF);
        cyc(0, 1, 1, 5, 32'hCAFEBABE, 4'hF);
        chk("collide_old", res, 32'h12345678);
        cyc(0, 1, 0, 5, 0, 0);
        chk("collide_new", res, 32'hCAFEBABE);

        // Out of range.
        cyc(0, 0, 1, 16, 32'hDEADBEEF, 4'hF);
        chk("oor_w_err", {31'b0, addr_err}, 32'h1);
        chk("oor_w_valid", {31'b0, r_valid}, 32'h0);
        cyc(0, 0, 1, 32'h80000003, 32'hDEADBEEF, 4'hF);
        cyc(0, 1, 0, 0, 0, 0);
        chk("oor_w_alias0", res, 32'h0);
        cyc(0, 1, 0, 3, 0, 0);
        chk("oor_w_alias3", res, 32'hAA22CC44);
        cyc(0, 1, 0, 32'h20, 0, 0);
        chk("oor_r_res", res, 32'h0);
        chk("oor_r_valid", {31'b0, r_valid}, 32'h1);
        chk("oor_r_err", {31'b0, addr_err}, 32'h1);
        cyc(0, 1, 0, 15, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("err_one_cycle", {31'b0, addr_err}, 32'h0);
        chk("idle_valid", {31'b0, r_valid}, 32'h0);

        // Reset mid-operation then reset mid-clear with requests during busy.
        cyc(1, 1, 1, 0, 32'hFFFFFFFF, 4'hF);
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, 0, 32'hFFFFFFFF, 4'hF);
        cyc(1, 0, 0, 0, 0, 0);
        chk("midclr_busy", {31'b0, busy}, 32'h1);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            cyc(0, 1, 1, 0, 32'hFFFFFFFF, 4'hF);
            if (busy === 1'b1) chk("busy_no_valid", {31'b0, r_valid}, 32'h0);
        end
        chk("midclr_len", n, 16);
        cyc(0, 1, 0, 0, 0, 0);
        chk("busy_no_write", res, 32'h0);
        cyc(0, 1, 0, 3, 0, 0);
        chk("recleared", res, 32'h0);

        // Streaming.
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, i, 32'hA5000000 | (i * 32'h00010101), 4'hF);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 1, 0, i, 0, 0);
            chk("stream_data", res, 32'hA5000000 | (i * 32'h00010101));
            chk("stream_valid", {31'b0, r_valid}, 32'h1);
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk("hold_res", res, 32'hA50F0F0F);
        cyc(0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
